// File: rtl/write_back_queue_pkg.sv
// Shared cache definitions used by dcache, write_back_queue and write_axi_buffer:
// line-size default, offset width helper and write-back entry layout.
package write_back_queue_pkg;

    localparam int CACHE_LINE_SIZE = 16;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int SIZE_W          = 3;
    localparam int STRB_W          = 4;

    // Line payload is kept outside the struct so its width can follow LINE_SIZE.
    typedef struct packed {
        logic              uncached;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int offset_width(input int line_size);
        return $clog2(line_size);
    endfunction

    // Uncached entries conflict at word granularity, cached ones at line granularity.
    function automatic logic addr_match(input logic [ADDR_W-1:0] addr, input logic uncached,
                                        input logic [ADDR_W-1:0] query, input int offw);
        logic [ADDR_W-1:0] mask;
        mask = uncached ? 32'hFFFF_FFFC : (32'hFFFF_FFFF << offw);
        return ((addr ^ query) & mask) == '0;
    endfunction

endpackage

// File: rtl/write_back_queue_mem.sv
// Entry storage for the write-back queue: one write port, one read port,
// plus every slot's address/uncached bit broadcast for hazard matching.
module wbq_mem
    import write_back_queue_pkg::*;
#(
    parameter int LINE_SIZE = CACHE_LINE_SIZE,
    parameter int DEPTH     = 4,
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             we_i,
    input  logic [PW-1:0]                    waddr_i,
    input  wb_entry_t                        wdata_i,
    input  logic [LINE_SIZE*8-1:0]           wline_i,
    input  logic [PW-1:0]                    raddr_i,
    output wb_entry_t                        rdata_o,
    output logic [LINE_SIZE*8-1:0]           rline_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]     slot_addr_o,
    output logic [DEPTH-1:0]                 slot_unc_o
);

    wb_entry_t              ent_q  [DEPTH];
    logic [LINE_SIZE*8-1:0] line_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            ent_q[waddr_i]  <= wdata_i;
            line_q[waddr_i] <= wline_i;
        end
    end

    assign rdata_o = ent_q[raddr_i];
    assign rline_o = line_q[raddr_i];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign slot_addr_o[i] = ent_q[i].addr;
        assign slot_unc_o[i]  = ent_q[i].uncached;
    end

endmodule

// File: rtl/write_back_queue.sv
// Write-back queue between dcache and write_axi_buffer: FIFO of dirty-line and
// uncached-word writes with read-after-write hazard detection on queued and in-flight entries.
module write_back_queue
    import write_back_queue_pkg::*;
#(
    parameter int LINE_SIZE = CACHE_LINE_SIZE,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_en,
    input  logic                   push_uncached,
    input  logic [31:0]            push_addr,
    input  logic [2:0]             push_size,
    input  logic [3:0]             push_wstrb,
    input  logic [31:0]            push_data,
    input  logic [LINE_SIZE*8-1:0] push_line,
    output logic                   full,
    output logic                   wb_en,
    output logic                   wb_uncached,
    output logic [31:0]            wb_addr,
    output logic [2:0]             wb_size,
    output logic [3:0]             wb_wstrb,
    output logic [31:0]            wb_data,
    output logic [LINE_SIZE*8-1:0] wb_line,
    input  logic                   wb_empty,
    input  logic [31:0]            query_addr,
    output logic                   query_hit,
    output logic                   idle
);

    localparam int         PW      = $clog2(DEPTH);
    localparam int         OFFW    = offset_width(LINE_SIZE);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          inflight_valid_q, inflight_valid_d;
    logic          inflight_uncached_q, inflight_uncached_d;
    logic [31:0]   inflight_addr_q, inflight_addr_d;

    logic                       push_ok, pop, head_vld;
    wb_entry_t                  push_ent, head_ent;
    logic [LINE_SIZE*8-1:0]     head_line;
    logic [DEPTH-1:0][31:0]     slot_addr;
    logic [DEPTH-1:0]           slot_unc, slot_vld, slot_hit;

    assign full     = (count_q == DEPTH_C);
    assign head_vld = (count_q != '0);
    assign push_ok  = push_en & ~full;
    assign wb_en    = head_vld & wb_empty;
    assign pop      = wb_en;
    assign idle     = ~head_vld & wb_empty;

    assign push_ent = '{uncached: push_uncached, addr: push_addr, size: push_size,
                        wstrb: push_wstrb, data: push_data};

    wbq_mem #(.LINE_SIZE(LINE_SIZE), .DEPTH(DEPTH)) u_mem (
        .clk         (clk),
        .we_i        (push_ok & ~rst),
        .waddr_i     (wr_ptr_q),
        .wdata_i     (push_ent),
        .wline_i     (push_line),
        .raddr_i     (rd_ptr_q),
        .rdata_o     (head_ent),
        .rline_o     (head_line),
        .slot_addr_o (slot_addr),
        .slot_unc_o  (slot_unc)
    );

    always_comb begin
        rd_ptr_d            = rd_ptr_q + PW'(pop);
        wr_ptr_d            = wr_ptr_q + PW'(push_ok);
        count_d             = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        inflight_valid_d    = inflight_valid_q;
        inflight_addr_d     = inflight_addr_q;
        inflight_uncached_d = inflight_uncached_q;
        if (pop) begin
            inflight_valid_d    = 1'b1;
            inflight_addr_d     = head_ent.addr;
            inflight_uncached_d = head_ent.uncached;
        end else if (wb_empty) begin
            inflight_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            inflight_valid_q <= 1'b0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            inflight_valid_q <= inflight_valid_d;
        end
    end

    // Payload of the in-flight register is qualified by inflight_valid_q only.
    always_ff @(posedge clk) begin
        inflight_addr_q     <= inflight_addr_d;
        inflight_uncached_q <= inflight_uncached_d;
    end

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] rel;
        assign rel         = PW'(i) - rd_ptr_q;
        assign slot_vld[i] = ({1'b0, rel} < count_q);
        assign slot_hit[i] = slot_vld[i] & addr_match(slot_addr[i], slot_unc[i], query_addr, OFFW);
    end

    assign query_hit = (|slot_hit) |
                       (inflight_valid_q & addr_match(inflight_addr_q, inflight_uncached_q, query_addr, OFFW));

    assign wb_uncached = head_vld & head_ent.uncached;
    assign wb_addr     = head_vld ? head_ent.addr  : '0;
    assign wb_size     = head_vld ? head_ent.size  : '0;
    assign wb_wstrb    = head_vld ? head_ent.wstrb : '0;
    assign wb_data     = head_vld ? head_ent.data  : '0;
    assign wb_line     = head_vld ? head_line      : '0;

endmodule

// File: tb/tb_write_back_queue.sv
// Bench for write_back_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_write_back_queue;

    localparam int LINE_SIZE = 16;
    localparam int DEPTH     = 4;
    localparam int LW        = LINE_SIZE * 8;
    localparam int OFFW      = $clog2(LINE_SIZE);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_en, push_uncached;
    logic [31:0]   push_addr, push_data, query_addr;
    logic [2:0]    push_size;
    logic [3:0]    push_wstrb;
    logic [LW-1:0] push_line;
    logic          full, wb_en, wb_uncached, wb_empty, query_hit, idle;
    logic [31:0]   wb_addr, wb_data;
    logic [2:0]    wb_size;
    logic [3:0]    wb_wstrb;
    logic [LW-1:0] wb_line;

    int n_cmp = 0;
    int n_err = 0;

    write_back_queue #(.LINE_SIZE(LINE_SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push_en(push_en), .push_uncached(push_uncached),
        .push_addr(push_addr), .push_size(push_size), .push_wstrb(push_wstrb),
        .push_data(push_data), .push_line(push_line), .full(full), .wb_en(wb_en),
        .wb_uncached(wb_uncached), .wb_addr(wb_addr), .wb_size(wb_size),
        .wb_wstrb(wb_wstrb), .wb_data(wb_data), .wb_line(wb_line),
        .wb_empty(wb_empty), .query_addr(query_addr), .query_hit(query_hit), .idle(idle)
    );

    always #5 clk = ~clk;

    // Behavioural model: list of pending writes plus the last popped write.
    typedef struct {
        bit          unc;
        bit [31:0]   addr;
        bit [2:0]    size;
        bit [3:0]    strb;
        bit [31:0]   data;
        bit [LW-1:0] line;
    } ent_t;

    ent_t      mq[$];
    bit        infl_v;
    bit        infl_unc;
    bit [31:0] infl_addr;

    function automatic bit conflicts(bit unc, bit [31:0] a, bit [31:0] qa);
        if (unc) return (a >> 2) == (qa >> 2);
        return (a >> OFFW) == (qa >> OFFW);
    endfunction

    function automatic bit model_hit(bit [31:0] qa);
        bit h = 0;
        foreach (mq[i]) if (conflicts(mq[i].unc, mq[i].addr, qa)) h = 1;
        if (infl_v && conflicts(infl_unc, infl_addr, qa)) h = 1;
        return h;
    endfunction

    task automatic tick();
        bit   do_pop, do_push;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            infl_v = 0;
        end else begin
            do_pop  = (mq.size() != 0) && wb_empty;
            do_push = push_en && (mq.size() < DEPTH);
            e = '{push_uncached, push_addr, push_size, push_wstrb, push_data, push_line};
            if (do_pop) begin
                infl_v    = 1;
                infl_unc  = mq[0].unc;
                infl_addr = mq[0].addr;
                void'(mq.pop_front());
            end else if (wb_empty) begin
                infl_v = 0;
            end
            if (do_push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(bit en, bit unc, bit [31:0] addr);
        push_en       = en;
        push_uncached = unc;
        push_addr     = addr;
        push_size     = 3'($urandom_range(0, 7));
        push_wstrb    = 4'($urandom);
        push_data     = $urandom;
        push_line     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1; wb_empty = 1; query_addr = 0;
        drive(1'b1, 1'b0, 32'h0000_0100);
        tick(); tick();
        rst = 0; drive(1'b0, 1'b0, 32'h0);
        #2;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got %0b want 0", wb_en); end
        n_cmp++; if (wb_addr !== 32'h0 || wb_line !== '0) begin n_err++; $display("FAIL reset_wb_zero got addr %h want 0", wb_addr); end
        query_addr = 32'h0000_0100; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL reset_query_hit got %0b want 0", query_hit); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %0b want 1", idle); end
        wb_empty = 0; #1;
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %0b want 0", idle); end
        wb_empty = 1;
    endtask

    task automatic test_single();
        bit [LW-1:0] line;
        wb_empty = 1;
        drive(1'b1, 1'b0, 32'h1000_0040);
        line = push_line;
        #2;
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got %0b want 0", wb_en); end
        tick();
        drive(1'b0, 1'b0, 32'h0);
        #2;
        n_cmp++; if (wb_en !== 1'b1 || wb_addr !== 32'h1000_0040) begin n_err++; $display("FAIL single_head got en %0b addr %h want 1 10000040", wb_en, wb_addr); end
        n_cmp++; if (wb_line !== line) begin n_err++; $display("FAIL single_line got %h want %h", wb_line, line); end
        tick();
        #2;
        n_cmp++; if (wb_en !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL single_drained got en %0b idle %0b want 0 1", wb_en, idle); end
        tick();
    endtask

    task automatic test_fill();
        bit [31:0] exp;
        wb_empty = 0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 32'(i * 32'h100));
            tick();
            if (i == 4) begin
                n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b want 1", full); end
            end
        end
        drive(1'b0, 1'b0, 32'h0);
        wb_empty = 1;
        for (int i = 1; i <= 4; i++) begin
            exp = 32'(i * 32'h100);
            #2;
            n_cmp++; if (wb_en !== 1'b1 || wb_addr !== exp) begin n_err++; $display("FAIL fill_order got en %0b addr %h want 1 %h", wb_en, wb_addr, exp); end
            tick();
        end
        #2;
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL fill_drop5 got %0b want 0", wb_en); end
        tick();
    endtask

    task automatic test_push_pop();
        bit [31:0] order [3];
        order = '{32'h1400, 32'h1600, 32'h0};
        wb_empty = 0;
        for (int i = 1; i <= 4; i++) begin drive(1'b1, 1'b0, 32'(32'h1000 + i * 32'h100)); tick(); end
        wb_empty = 1;
        drive(1'b1, 1'b0, 32'h1500);
        tick();
        #2;
        n_cmp++; if (full !== 1'b0 || wb_addr !== 32'h1200) begin n_err++; $display("FAIL pp_full_drop got full %0b head %h want 0 1200", full, wb_addr); end
        drive(1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h1600);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (wb_addr !== order[i] || wb_en !== (i < 2)) begin n_err++; $display("FAIL pp_order got en %0b addr %h want %h", wb_en, wb_addr, order[i]); end
            tick();
        end
    endtask

    task automatic test_hazard();
        wb_empty = 0;
        drive(1'b1, 1'b0, 32'h2000_0010); tick();
        drive(1'b1, 1'b1, 32'h3000_0004); tick();
        drive(1'b0, 1'b0, 32'h0);
        query_addr = 32'h2000_001C; #2;
        n_cmp++; if (query_hit !== 1'b1) begin n_err++; $display("FAIL hz_same_line got %0b want 1", query_hit); end
        query_addr = 32'h2000_0020; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL hz_next_line got %0b want 0", query_hit); end
        query_addr = 32'h3000_0008; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL hz_unc_other_word got %0b want 0", query_hit); end
        query_addr = 32'h3000_0007; #1;
        n_cmp++; if (query_hit !== 1'b1) begin n_err++; $display("FAIL hz_unc_same_word got %0b want 1", query_hit); end
        drive(1'b1, 1'b0, 32'h5000_0000);
        query_addr = 32'h5000_0004; #1;
        n_cmp++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL hz_same_cycle_push got %0b want 0", query_hit); end
        tick();
        drive(1'b0, 1'b0, 32'h0);
        #2;
        n_cmp++; if (query_hit !== 1'b1) begin n_err++; $display("FAIL hz_next_cycle_push got %0b want 1", query_hit); end
        wb_empty = 1;
        for (int i = 0; i < 5; i++) tick();
        query_addr = 32'h2000_0010; #1;
        n_cmp++; if (query_hit !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL hz_drained got hit %0b idle %0b want 0 1", query_hit, idle); end
    endtask

    task automatic test_inflight();
        wb_empty = 0;
        drive(1'b1, 1'b0, 32'h4000_0000); tick();
        drive(1'b0, 1'b0, 32'h0);
        wb_empty = 1; tick();
        wb_empty = 0;
        query_addr = 32'h4000_0004; #2;
        n_cmp++; if (query_hit !== 1'b1 || wb_en !== 1'b0) begin n_err++; $display("FAIL if_busy got hit %0b en %0b want 1 0", query_hit, wb_en); end
        tick();
        #2;
        n_cmp++; if (query_hit !== 1'b1) begin n_err++; $display("FAIL if_hold got %0b want 1", query_hit); end
        wb_empty = 1;
        tick();
        #2;
        n_cmp++; if (query_hit !== 1'b0) begin n_err++; $display("FAIL if_clear got %0b want 0", query_hit); end
    endtask

    task automatic test_reset_mid();
        wb_empty = 0;
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 32'(32'h6000_0000 + i * 32'h40)); tick(); end
        rst = 1;
        drive(1'b1, 1'b0, 32'h7000_0000);
        tick();
        rst = 0; wb_empty = 1;
        drive(1'b0, 1'b0, 32'h0);
        query_addr = 32'h6000_0000; #2;
        n_cmp++; if (full !== 1'b0 || wb_en !== 1'b0 || query_hit !== 1'b0) begin n_err++; $display("FAIL rm_state got full %0b en %0b hit %0b want 0 0 0", full, wb_en, query_hit); end
        query_addr = 32'h7000_0000; #1;
        n_cmp++; if (query_hit !== 1'b0 || idle !== 1'b1) begin n_err++; $display("FAIL rm_push_dropped got hit %0b idle %0b want 0 1", query_hit, idle); end
        tick();
    endtask

    task automatic test_random();
        bit [31:0] pool [6];
        ent_t      h;
        bit        e_en;
        pool = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0014, 32'h9000_0000, 32'h9000_0020};
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wb_empty = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)));
            query_addr = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 7));
            #2;
            e_en = (mq.size() != 0) && wb_empty;
            h = (mq.size() != 0) ? mq[0] : '{0, 0, 0, 0, 0, 0};
            n_cmp++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full c%0d got %0b want %0b", c, full, mq.size() == DEPTH); end
            n_cmp++; if (wb_en !== e_en) begin n_err++; $display("FAIL rnd_wb_en c%0d got %0b want %0b", c, wb_en, e_en); end
            n_cmp++; if ({wb_uncached, wb_addr, wb_size, wb_wstrb, wb_data} !== {h.unc, h.addr, h.size, h.strb, h.data})
                begin n_err++; $display("FAIL rnd_head c%0d got addr %h data %h want %h %h", c, wb_addr, wb_data, h.addr, h.data); end
            n_cmp++; if (wb_line !== h.line) begin n_err++; $display("FAIL rnd_line c%0d got %h want %h", c, wb_line, h.line); end
            n_cmp++; if (query_hit !== model_hit(query_addr)) begin n_err++; $display("FAIL rnd_hit c%0d q %h got %0b want %0b", c, query_addr, query_hit, model_hit(query_addr)); end
            n_cmp++; if (idle !== ((mq.size() == 0) && wb_empty)) begin n_err++; $display("FAIL rnd_idle c%0d got %0b", c, idle); end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; wb_empty = 1; query_addr = 0;
        drive(1'b0, 1'b0, 32'h0);
        test_reset();
        test_single();
        test_fill();
        test_push_pop();
        test_hazard();
        test_inflight();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 16, meaning cache line size in bytes; it must be a power of two and at least 4.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; it must be a power of two and at least 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 push_en  in  1  dcache requests an enqueue this cycle.
REQ-006 push_uncached  in  1  entry is a single uncached word, not a line write-back.
REQ-007 push_addr  in  32  write address.
REQ-008 push_size  in  3  AXI awsize.
REQ-009 push_wstrb  in  4  byte strobe (uncached only).
REQ-010 push_data  in  32  uncached write data.
REQ-011 push_line  in  LINE_SIZE*8  dirty line data.
REQ-012 full  out  1  queue holds DEPTH entries.
REQ-013 wb_en  out  1  head entry offered to write_axi_buffer.
REQ-014 wb_uncached, wb_addr, wb_size, wb_wstrb, wb_data, wb_line  out  1/32/3/4/32/LINE_SIZE*8  head entry fields.
REQ-015 wb_empty  in  1  write_axi_buffer empty (idle) flag.
REQ-016 query_addr  in  32  dcache read-miss address for hazard check.
REQ-017 query_hit  out  1  query_addr conflicts with a queued or in-flight write.
REQ-018 idle  out  1  queue empty and write_axi_buffer empty.

Function
REQ-019 Push: accepted iff push_en & ~full; push_en while full SHALL be dropped even with a simultaneous pop; full = (count == DEPTH), registered-count based.
REQ-020 Pop: wb_en = (count != 0) & wb_empty; pop occurs in the same cycle wb_en is high; wb_* SHALL show the head entry whenever count != 0, else zeros.
REQ-021 Latency: an entry pushed into an empty queue SHALL appear on wb_* the next cycle; no same-cycle bypass.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-023 Pointers: rd_ptr/wr_ptr are log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-024 In-flight tracking: on pop, latch popped addr and uncached into inflight_addr and inflight_uncached, and set inflight_valid; when wb_empty=1 and no pop occurs, clear inflight_valid.
REQ-025 Match rule, cached entry: addr[31:log2(LINE_SIZE)] equals query_addr[31:log2(LINE_SIZE)]; uncached entry: addr[31:2] equals query_addr[31:2].
REQ-026 query_hit SHALL be combinational OR of the match over all valid queue slots plus the in-flight register; it is 0 when nothing is valid.
REQ-027 Entries pushed in the current cycle SHALL NOT contribute to query_hit until the following cycle.
REQ-028 idle = (count == 0) & wb_empty.
REQ-029 Duplicate addresses SHALL be queued independently without merging.

Reset
REQ-030 On rst: count=0, pointers=0, inflight_valid=0; therefore full=0, wb_en=0, wb_* = 0, query_hit=0, idle=wb_empty.
REQ-031 rst asserted mid-operation SHALL discard all queued entries; a push or pop in the reset cycle SHALL have no effect.
REQ-032 Entry storage need not be reset.

Structure
REQ-033 Shared cache package SHALL hold LINE_SIZE default, the offset-width function log2(LINE_SIZE), and the entry-field widths; these are shared with dcache and write_axi_buffer.
REQ-034 Storage SHALL be a single sub-module wbq_mem: a DEPTH-entry register array with one write port and one read port, exposing all slot addresses and uncached bits for matching.

Verification
REQ-035 Directed test 1, single cached write: wb_empty=1, push cached 0x1000_0040 -> next cycle wb_en=1 with wb_addr=0x1000_0040; same cycle pop; count returns to 0.
REQ-036 Directed test 2, fill and overflow: wb_empty=0, 5 pushes 0x100,0x200,0x300,0x400,0x500 -> full=1 after the 4th; 5th dropped; after release, pop order is 0x100..0x400 only.
REQ-037 Directed test 3, push and pop together: count=4 with a push while popping -> push dropped; count=2 with a push while popping -> count stays 2 and the new entry is last.
REQ-038 Directed test 4, hazard: cached 0x2000_0010 queued, query 0x2000_001C -> query_hit=1; query 0x2000_0020 -> 0; uncached 0x3000_0004 queued, query 0x3000_0008 -> 0.
REQ-039 Directed test 5, in-flight: pop 0x4000_0000, then query 0x4000_0004 while wb_empty=0 -> query_hit=1; the cycle after wb_empty returns to 1 -> query_hit=0.
REQ-040 Directed test 6, reset mid-operation: 3 entries queued, rst for 1 cycle -> count=0, wb_en=0, query_hit=0, full=0; a push in the reset cycle is absent afterwards.
